// File: rtl/sd_clk_pkg.sv
// sd_clk_pkg: shared constants and FSM encoding for the SD clock divider.
package sd_clk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } sd_clk_state_e;

    localparam int unsigned SYS_CLK_HZ    = 50_000_000;
    localparam int unsigned ID_COUNT_DEF  = 125;   // 50 MHz / 125 = 400 kHz
    localparam int unsigned MIN_COUNT_DEF = 2;     // fastest legal sd_clk: 25 MHz

endpackage

// File: rtl/sd_clk_divider_reg.sv
// sd_clk_divider_reg: generic enabled register with synchronous active-low reset.
module sd_clk_divider_reg #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold value unless enabled; reset to RST_VAL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/sd_clk_divider.sv
// sd_clk_divider: glitch-free SD card clock generator from the system clock.
// Count changes and start/stop happen only at period boundaries (the last LOW
// cycle), so sd_clk never produces a runt pulse.
// Optional macro SD_CLK_HOLD_EN adds a 'hold' input that stretches the LOW
// phase for data-buffer flow control.
module sd_clk_divider
    import sd_clk_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ID_COUNT  = ID_COUNT_DEF,
    parameter int unsigned MIN_COUNT = MIN_COUNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] count,
    input  logic             id_mode,
`ifdef SD_CLK_HOLD_EN
    input  logic             hold,
`endif
    output logic             sd_clk,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running,
    output logic             pending,
    output logic [WIDTH-1:0] cur_count
);

    sd_clk_state_e    state_r, state_nxt_s;
    logic [WIDTH-1:0] phase_r, phase_nxt_s;
    logic [WIDTH-1:0] cur_count_r, cur_count_nxt_s;
    logic             pending_r, pending_nxt_s;
    logic             sd_clk_r, sd_clk_nxt_s;
    logic             rise_r, rise_nxt_s;
    logic             fall_r, fall_nxt_s;
    logic             running_r;
    logic [WIDTH-1:0] pend_count_s;
    logic [WIDTH-1:0] load_val_s;
    logic [WIDTH-1:0] high_len_s, low_len_s, eff_count_s;
    logic             last_high_s, last_low_s, boundary_s, hold_s;

`ifdef SD_CLK_HOLD_EN
    assign hold_s = hold;
`else
    assign hold_s = 1'b0;
`endif

    // Clamp incoming counts so a period is never shorter than MIN_COUNT.
    always_comb begin
        if (count < WIDTH'(MIN_COUNT)) begin
            load_val_s = WIDTH'(MIN_COUNT);
        end else begin
            load_val_s = count;
        end
    end

    sd_clk_divider_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL ({WIDTH{1'b0}})
    ) u_pend_count (
        .clk   (clk),
        .reset (reset),
        .en    (load),
        .d     (load_val_s),
        .q     (pend_count_s)
    );

    // Phase lengths and the count a boundary would switch to.
    always_comb begin
        high_len_s  = cur_count_r >> 1;
        low_len_s   = cur_count_r - high_len_s;
        last_high_s = (phase_r == (high_len_s - WIDTH'(1)));
        last_low_s  = (phase_r == (low_len_s - WIDTH'(1)));
        if (id_mode) begin
            eff_count_s = WIDTH'(ID_COUNT);
        end else if (pending_r) begin
            eff_count_s = pend_count_s;
        end else begin
            eff_count_s = cur_count_r;
        end
    end

    // Next-state and next-output logic for the IDLE/HIGH/LOW sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        phase_nxt_s     = phase_r;
        sd_clk_nxt_s    = sd_clk_r;
        rise_nxt_s      = 1'b0;
        fall_nxt_s      = 1'b0;
        boundary_s      = 1'b0;
        cur_count_nxt_s = cur_count_r;
        pending_nxt_s   = pending_r;
        case (state_r)
            IDLE: begin
                phase_nxt_s  = {WIDTH{1'b0}};
                sd_clk_nxt_s = 1'b0;
                if (en) begin
                    boundary_s   = 1'b1;
                    state_nxt_s  = HIGH;
                    sd_clk_nxt_s = 1'b1;
                    rise_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            HIGH: begin
                if (last_high_s) begin
                    state_nxt_s  = LOW;
                    phase_nxt_s  = {WIDTH{1'b0}};
                    sd_clk_nxt_s = 1'b0;
                    fall_nxt_s   = 1'b1;
                end else begin
                    phase_nxt_s  = phase_r + WIDTH'(1);
                end
            end
            LOW: begin
                if (last_low_s) begin
                    if (hold_s) begin
                        // Stretch LOW: stay on the last cycle until hold drops.
                        state_nxt_s  = LOW;
                    end else if (en) begin
                        boundary_s   = 1'b1;
                        state_nxt_s  = HIGH;
                        phase_nxt_s  = {WIDTH{1'b0}};
                        sd_clk_nxt_s = 1'b1;
                        rise_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s  = IDLE;
                        phase_nxt_s  = {WIDTH{1'b0}};
                        sd_clk_nxt_s = 1'b0;
                    end
                end else begin
                    phase_nxt_s  = phase_r + WIDTH'(1);
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                phase_nxt_s  = {WIDTH{1'b0}};
                sd_clk_nxt_s = 1'b0;
            end
        endcase

        // Boundary adopts the selected count; id_mode leaves pending alone.
        if (boundary_s) begin
            cur_count_nxt_s = eff_count_s;
            if (!id_mode && pending_r) begin
                pending_nxt_s = 1'b0;
            end else begin
                pending_nxt_s = pending_r;
            end
        end else begin
            cur_count_nxt_s = cur_count_r;
        end

        // A load in the boundary cycle stays pending for the next boundary.
        if (load) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Phase counter, count bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_r     <= {WIDTH{1'b0}};
            cur_count_r <= WIDTH'(ID_COUNT);
            pending_r   <= 1'b0;
            sd_clk_r    <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            phase_r     <= phase_nxt_s;
            cur_count_r <= cur_count_nxt_s;
            pending_r   <= pending_nxt_s;
            sd_clk_r    <= sd_clk_nxt_s;
            rise_r      <= rise_nxt_s;
            fall_r      <= fall_nxt_s;
            running_r   <= (state_nxt_s != IDLE);
        end
    end

    assign sd_clk    = sd_clk_r;
    assign rise_stb  = rise_r;
    assign fall_stb  = fall_r;
    assign running   = running_r;
    assign pending   = pending_r;
    assign cur_count = cur_count_r;

endmodule

// File: tb/tb_sd_clk_divider.sv
// tb_sd_clk_divider: randomized and directed stimulus against a period-level
// reference model (one position counter per SD period, clock level derived
// from position < C/2, strobes derived from sd_clk level changes).
module tb_sd_clk_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, en, load, id_mode, hold;
    logic [W-1:0] count;
    logic         sd_clk, rise_stb, fall_stb, running, pending;
    logic [W-1:0] cur_count;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit m_act;
    int m_t;
    int m_c;
    bit m_pend;
    int m_pval;
    bit m_sd, m_rise, m_fall;

    always #10 clk = ~clk;

    sd_clk_divider dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .count     (count),
        .id_mode   (id_mode),
`ifdef SD_CLK_HOLD_EN
        .hold      (hold),
`endif
        .sd_clk    (sd_clk),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .running   (running),
        .pending   (pending),
        .cur_count (cur_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30) begin
                $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
            end
        end
    endtask

    // Advance the model by one system clock using the inputs sampled at the edge.
    task automatic model_step();
        bit bnd;
        bit prev_sd;
        bit hold_v;
`ifdef SD_CLK_HOLD_EN
        hold_v = hold;
`else
        hold_v = 1'b0;
`endif
        prev_sd = m_sd;
        if (!reset) begin
            m_act = 0; m_t = 0; m_c = 125; m_pend = 0; m_pval = 0;
            m_sd = 0; m_rise = 0; m_fall = 0;
            return;
        end
        bnd = 0;
        if (!m_act) begin
            bnd = en;
        end else if (m_t == m_c - 1) begin
            if (hold_v) begin
                bnd = 0;
            end else if (en) begin
                bnd = 1;
            end else begin
                m_act = 0;
            end
        end else begin
            m_t++;
        end
        if (bnd) begin
            m_act = 1;
            m_t   = 0;
            if (id_mode) begin
                m_c = 125;
            end else if (m_pend) begin
                m_c    = m_pval;
                m_pend = 0;
            end
        end
        if (load) begin
            m_pend = 1;
            m_pval = (count < 2) ? 2 : int'(count);
        end
        m_sd   = m_act && (m_t < m_c / 2);
        m_rise = m_sd && !prev_sd;
        m_fall = !m_sd && prev_sd;
    endtask

    task automatic check_all();
        chk("sd_clk",    sd_clk,    m_sd);
        chk("rise_stb",  rise_stb,  m_rise);
        chk("fall_stb",  fall_stb,  m_fall);
        chk("running",   running,   m_act);
        chk("pending",   pending,   m_pend);
        chk("cur_count", cur_count, m_c);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_strobe(input bit want_rise);
        int n;
        n = 0;
        while (((want_rise ? rise_stb : fall_stb) !== 1'b1) && (n < 300)) begin
            step();
            n++;
        end
        chk("wait_bound", (n < 300), 1);
    endtask

    task automatic do_load(input int val);
        load  = 1'b1;
        count = W'(val);
        step();
        load  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; count = '0; id_mode = 1'b0; hold = 1'b0;
        m_act = 0; m_t = 0; m_c = 125; m_pend = 0; m_pval = 0;
        m_sd = 0; m_rise = 0; m_fall = 0;
        repeat (3) step();
        reset = 1'b1;

        // Identification-mode clock: 125-cycle period.
        en = 1'b1; id_mode = 1'b1;
        repeat (300) step();

        // Fastest clock, then 5, then clamped 0.
        id_mode = 1'b0;
        do_load(2);  repeat (200) step();
        do_load(5);  repeat (40)  step();
        do_load(0);  repeat (20)  step();

        // Two loads in one period: the last one wins.
        do_load(10); repeat (30) step();
        wait_strobe(1'b1);
        do_load(30); repeat (5) step();
        do_load(6);  repeat (60) step();

        // Drop en mid-HIGH with C=10: period completes, then idle.
        do_load(10); repeat (30) step();
        wait_strobe(1'b1);
        step();
        en = 1'b0;
        repeat (25) step();

        // Restart, then reset mid-LOW.
        en = 1'b1;
        wait_strobe(1'b0);
        step(); step();
        reset = 1'b0; step();
        reset = 1'b1; repeat (20) step();

`ifdef SD_CLK_HOLD_EN
        // Hold stretches the LOW phase with C=4.
        do_load(4); repeat (20) step();
        wait_strobe(1'b0);
        step();
        hold = 1'b1; repeat (7) step();
        hold = 1'b0; repeat (20) step();
`endif

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 599) != 0);
            en      = ($urandom_range(0, 19) != 0);
            id_mode = ($urandom_range(0, 39) == 0);
            load    = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       count = W'($urandom_range(0, 3));
                1:       count = W'($urandom_range(4, 12));
                default: count = W'($urandom_range(13, 40));
            endcase
            hold = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
